// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: lights one digit at a time, with dark anti-ghosting gaps between digits.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scanner #(
   parameter int DIGITS       = 6,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic [DIGITS*7-1:0]   seven_seg_i,
   output logic [6:0]            segments_o,
   output logic [DIGITS-1:0]     digit_sel_o,
   output logic                  frame_o
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] sel_q, sel_d;
   logic              frame_q, frame_d;

   logic [6:0]        pat [DIGITS];
   logic [IDX_W-1:0]  idx_next;
   logic [IDX_W-1:0]  load_idx;
   logic [6:0]        pat_sel;

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         pat[i] = seven_seg_i[i*7 +: 7];
      end
   end

   // The digit about to be lit: the held index when leaving BLANK, the next one on a direct SHOW->SHOW step.
   always_comb begin
      idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      load_idx = (state_q == ST_SHOW) ? idx_next : idx_q;
   end

`ifdef SEVEN_SEG_LZB_EN
   logic [DIGITS-1:0] lead_zero;

   always_comb begin
      logic all_zero;
      all_zero  = 1'b1;
      lead_zero = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         all_zero     = all_zero && (pat[i] == 7'h3F);
         lead_zero[i] = all_zero;
      end
      pat_sel = lead_zero[load_idx] ? 7'h00 : pat[load_idx];
   end
`else
   always_comb begin
      pat_sel = pat[load_idx];
   end
`endif

   // NOTE: every _d gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      logic load;
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      seg_d   = seg_q;
      sel_d   = sel_q;
      frame_d = 1'b0;
      load    = 1'b0;

      if (!enable_i) begin
         state_d = ST_BLANK;
         cnt_d   = '0;
         seg_d   = '0;
         sel_d   = '0;
      end else begin
         case (state_q)
            ST_BLANK: begin
               if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
                  state_d = ST_SHOW;
                  cnt_d   = '0;
                  load    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_SHOW: begin
               if (cnt_q == DWELL_LAST) begin
                  idx_d = idx_next;
                  cnt_d = '0;
                  if (BLANK_CYCLES == 0) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_BLANK;
                     seg_d   = '0;
                     sel_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_BLANK;
         endcase
      end

      if (load) begin
         seg_d   = pat_sel;
         sel_d   = DIGITS'(1) << load_idx;
         frame_d = (load_idx == '0);
      end
   end

   // NOTE: state updates use <= so every flop samples the pre-edge values; the async reset blanks the display at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_BLANK;
         idx_q   <= '0;
         cnt_q   <= '0;
         seg_q   <= '0;
         sel_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
         frame_q <= frame_d;
      end
   end

   assign segments_o  = seg_q;
   assign digit_sel_o = sel_q;
   assign frame_o     = frame_q;

endmodule
